// File: rtl/pipelined_carry_select_subtractor.sv
// Streaming pipelined subtractor: diff = a - b - borrow_in, one SLICE-bit chunk per stage.
// Each stage precomputes both borrow-in candidates and the registered borrow selects one.
module pipelined_carry_select_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSTAGE = WIDTH / SLICE;
  localparam int unsigned LAST   = NSTAGE - 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("WIDTH must be an integer multiple of SLICE");
  end

  logic              advance;
  logic [NSTAGE-1:0] vld_q;
  logic [NSTAGE-1:0] brw_q;
  logic [WIDTH-1:0]  a_q [NSTAGE];
  logic [WIDTH-1:0]  b_q [NSTAGE];
  logic [WIDTH-1:0]  d_q [NSTAGE];
  logic              ovf_q;
  logic              zero_q;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers.
  logic [WIDTH-1:0]  src_a [NSTAGE];
  logic [WIDTH-1:0]  src_b [NSTAGE];
  logic [WIDTH-1:0]  src_d [NSTAGE];
  logic [NSTAGE-1:0] src_bin;
  logic [NSTAGE-1:0] src_vld;
  logic [WIDTH-1:0]  d_nxt [NSTAGE];
  logic [NSTAGE-1:0] brw_nxt;
  logic              ovf_nxt;
  logic              zero_nxt;

  assign advance  = !vld_q[LAST] || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [SLICE:0] r0;
    logic [SLICE:0] r1;
    logic [SLICE:0] sel;
    r0  = '0;
    r1  = '0;
    sel = '0;
    src_a[0]   = a;
    src_b[0]   = b;
    src_d[0]   = '0;
    src_bin[0] = borrow_in;
    src_vld[0] = in_valid;
    for (int k = 1; k < NSTAGE; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_d[k]   = d_q[k-1];
      src_bin[k] = brw_q[k-1];
      src_vld[k] = vld_q[k-1];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      r1  = {1'b0, src_a[k][k*SLICE +: SLICE]} + {1'b0, ~src_b[k][k*SLICE +: SLICE]};
      r0  = r1 + (SLICE+1)'(1);
      sel = src_bin[k] ? r1 : r0;
      d_nxt[k] = src_d[k];
      d_nxt[k][k*SLICE +: SLICE] = sel[SLICE-1:0];
      brw_nxt[k] = ~sel[SLICE];
    end
    ovf_nxt  = (src_a[LAST][WIDTH-1] != src_b[LAST][WIDTH-1]) &&
               (d_nxt[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_nxt = (d_nxt[LAST] == '0);
  end

  // Data registers load only with a valid op so flags hold their last value on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      brw_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= src_vld;
      for (int k = 0; k < NSTAGE; k++) begin
        if (src_vld[k]) begin
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          d_q[k]   <= d_nxt[k];
          brw_q[k] <= brw_nxt[k];
        end
      end
      if (src_vld[LAST]) begin
        ovf_q  <= ovf_nxt;
        zero_q <= zero_nxt;
      end
    end
  end

  assign out_valid  = vld_q[LAST];
  assign diff       = d_q[LAST];
  assign borrow_out = brw_q[LAST];
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Randomized and directed bench for pipelined_carry_select_subtractor against an
// arithmetic reference model with an in-order scoreboard.
module tb_pipelined_carry_select_subtractor;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  int n_checks;
  int n_errors;

  logic [18:0] exp_q [$];
  logic        fired;
  logic        held;
  logic [19:0] held_val;

  pipelined_carry_select_subtractor #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packed {diff, borrow_out, overflow, zero} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic bi);
    int          ua;
    int          ub;
    logic [31:0] full;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    ua   = int'(av);
    ub   = int'(bv);
    full = 32'(ua - ub - int'(bi));
    d    = full[15:0];
    bo   = (ua < ub + int'(bi));
    ov   = (av[15] != bv[15]) && (d[15] != av[15]);
    return {d, bo, ov, (d == 16'h0)};
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      fired = 1'b0;
      held  = 1'b0;
    end else begin
      if (held) check("stall_hold", {12'h0, out_valid, diff, borrow_out, overflow, zero},
                      {12'h0, 1'b1, held_val[18:0]});
      if (out_valid && !out_ready) check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      fired = in_valid && in_ready;
      if (fired) exp_q.push_back(model(a, b, borrow_in));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'h1, 32'h0);
        else check("result", {13'h0, diff, borrow_out, overflow, zero},
                   {13'h0, exp_q.pop_front()});
      end
      held     = out_valid && !out_ready;
      held_val = {1'b0, diff, borrow_out, overflow, zero};
    end
  end

  task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input logic [18:0] exp, input string tag);
    int lat;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bi;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check(tag, {13'h0, diff, borrow_out, overflow, zero}, {13'h0, exp});
  endtask

  // rnd=1: random valid/ready; rnd=0: back-to-back with out_ready low in cycles 5-7.
  task automatic stream(input int n, input bit rnd);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < n) begin
      @(posedge clk); #1;
      cyc++;
      if (fired) sent++;
      if (!in_valid || fired) begin
        if (sent < n) begin
          in_valid  = rnd ? ($urandom_range(3) != 0) : 1'b1;
          a         = 16'($urandom);
          b         = 16'($urandom);
          borrow_in = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= 5 && cyc <= 7);
      if (cyc > 60000) begin
        check("stream_budget", 32'(sent), 32'(n));
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("reset_outputs", {13'h0, diff, borrow_out, overflow, zero}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run_one(16'h1234, 16'h0234, 1'b0, {16'h1000, 3'b000}, "basic");
    run_one(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b100}, "borrow_ripple");
    run_one(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b010}, "ovf_neg");
    run_one(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 3'b110}, "ovf_pos");
    run_one(16'h0005, 16'h0004, 1'b1, {16'h0000, 3'b001}, "zero_bin");

    stream(8, 1'b0);

    // Three ops in flight, oldest parked at the output, then async reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      a         = 16'($urandom);
      b         = 16'($urandom);
      borrow_in = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("preflush_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'h0, out_valid}, 32'h0);
    check("async_in_ready", {31'h0, in_ready}, 32'h1);
    check("async_diff", {16'h0, diff}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_stale_valid", {31'h0, out_valid}, 32'h0);
    check("post_reset_ready", {31'h0, in_ready}, 32'h1);
    run_one(16'h00FF, 16'h0100, 1'b0, {16'hFFFF, 3'b100}, "post_reset");

    stream(10000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_select_subtractor.md
Name: pipelined_carry_select_subtractor

Overview:
- Streaming unsigned/two's-complement subtractor: computes diff = a - b - borrow_in over WIDTH bits.
- Companion to the carry-select adder slices, using the same select principle in reverse (borrow select).
- Each SLICE-bit chunk has two precomputed results, one for borrow-in 0 and one for borrow-in 1. The registered borrow from the previous stage picks between them.
- Pipeline has one stage per slice, with a valid/ready handshake on both ends. Sits on the arithmetic datapath feeding comparator/ALU result muxes.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits resolved per pipeline stage. NSTAGE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  initial borrow
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - borrow_in mod 2^WIDTH
- borrow_out  output  1  1 when unsigned a < b + borrow_in
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]
- zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, async): all stage valid bits cleared.
  - out_valid=0, diff=0, borrow_out=0, overflow=0, zero=0.
  - in_ready follows the combinational rule below, so it is 1 after reset.
- Global stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, every stage register holds, including the valid bits.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Bubbles propagate: stage k valid <= stage k-1 valid when advance.
- Stage k (k = 0..NSTAGE-1) handles slice bits [k*SLICE +: SLICE].
  - Two candidates: r0 = a_k + ~b_k + 1 and r1 = a_k + ~b_k, each SLICE+1 bits wide.
  - Selector is the incoming borrow: borrow_in for stage 0, the registered borrow of stage k-1 otherwise.
  - Outgoing borrow = NOT carry of the selected candidate.
- Skew registers:
  - Unprocessed upper slices of a and b are carried forward per stage.
  - Completed lower diff slices are carried forward per stage.
  - a[MSB] and b[MSB] are carried for the overflow calculation.
- Latency: a result appears on out_valid exactly NSTAGE cycles after input acceptance, when no stall occurs (4 cycles at defaults). Throughput is 1 op/cycle.
- Output stability: diff, borrow_out, overflow and zero are registered. They stay stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order. No drop or duplication under any in_valid/out_ready pattern.
- Simultaneous events:
  - Full pipeline with out_ready=1 accepts a new op in the same cycle the oldest retires.
  - in_valid while stalled is not accepted; the producer must hold a, b and borrow_in.
- Reset mid-operation: all in-flight ops are discarded. After reset release no stale out_valid appears.
- Flags on invalid cycles: values are don't-care but must be deterministic (hold last).
- Elaboration: if WIDTH % SLICE != 0, fail via generate-time error.

Test Plan (WIDTH=16, SLICE=4):
- a=0x1234, b=0x0234, borrow_in=0 -> 4 cycles later: diff=0x1000, borrow_out=0, overflow=0, zero=0.
- a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, overflow=0. Exercises the borrow ripple through all 4 stages.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow_out=0, overflow=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow_out=1, overflow=1.
- a=0x0005, b=0x0004, borrow_in=1 -> diff=0x0000, zero=1, borrow_out=0.
- Back-to-back stream of 8 random ops, with out_ready low for cycles 5-7 -> in_ready=0 during the stall, outputs held stable. All 8 results emerge in order and match a reference model. 10k random ops with random valid/ready show zero mismatches.
- Assert rst_n low with 3 ops in flight -> out_valid=0 immediately (asynchronous). After release, in_ready=1, no spurious outputs, and the next op completes with 4-cycle latency.
